// File: rtl/mode_ctrl.sv
// mode_ctrl: piano mode sequencer with button edge detect, system tick and output mux.
// Define MODE_CTRL_MAP_EN to build the key-remap table, the MAP state and remap_clr.
module mode_ctrl #(
  parameter int KEYS = 7,
  parameter int NMODES = 4,
  parameter logic [NMODES-1:0] SONG_MASK = 4'b1110,
  parameter int SONGS = 3,
  parameter int LVL_MAX = 6,
  parameter int LVL_INIT = 4,
  parameter int CLK_DIV = 100000,
  parameter int TICK_W = 16,
  parameter int TUBE_W = 8,
  localparam int SONG_W = $clog2(SONGS + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         submit,
  input  logic                         cancel,
  input  logic                         oct_up,
  input  logic                         oct_down,
  input  logic                         remap_clr,
  input  logic [KEYS-1:0]              note_key,
  output logic [KEYS-1:0]              key_map,
  output logic                         tick,
  output logic [TICK_W-1:0]            sys_time,
  output logic [1:0]                   state,
  output logic [NMODES-1:0]            mode_en,
  output logic [SONG_W-1:0]            song,
  output logic [3:0]                   level,
  input  logic [NMODES-1:0]            mode_done,
  input  logic [NMODES-1:0]            eng_buzzer,
  input  logic [NMODES*KEYS-1:0]       eng_led,
  input  logic [NMODES*3*TUBE_W-1:0]   eng_seg,
  input  logic [3*TUBE_W-1:0]          menu_seg,
  output logic                         buzzer,
  output logic [KEYS-1:0]              led,
  output logic [3*TUBE_W-1:0]          seg
);

  localparam int MW = (NMODES > 1) ? $clog2(NMODES) : 1;
  localparam int KW = $clog2(KEYS + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [KW-1:0] NMODES_K = KW'(NMODES);
  localparam logic [KW-1:0] SONGS_K  = KW'(SONGS);
  localparam logic [KW-1:0] K_LAST   = KW'(KEYS - 1);
  localparam logic [3:0]    LVL_MAX_L  = 4'(LVL_MAX);
  localparam logic [3:0]    LVL_INIT_L = 4'(LVL_INIT);

  typedef enum logic [1:0] {MENU = 2'd0, PICK = 2'd1, RUN = 2'd2, MAP = 2'd3} state_t;

  state_t                state_reg, state_next;
  logic [NMODES-1:0]     mode_en_reg, mode_en_next;
  logic [MW-1:0]         sel_reg, sel_next;
  logic [SONG_W-1:0]     song_reg, song_next;
  logic [3:0]            level_reg, level_next;
  logic [KW-1:0]         k_reg, k_next;
  logic [3:0]            btn, btn_q, rise;
  logic                  sub_rise, can_rise, up_rise, dn_rise;
  logic                  key_onehot, map_we, map_clr;
  logic [KW-1:0]         key_idx;
  logic [MW-1:0]         mode_idx;
  logic [DW-1:0]         div_reg;
  logic                  tick_reg;
  logic [TICK_W-1:0]     time_reg;
  logic                  buzzer_next;
  logic [KEYS-1:0]       led_next;
  logic [3*TUBE_W-1:0]   seg_next;

  // Cancel outranks submit when both rise on the same edge.
  assign btn      = {submit, cancel, oct_up, oct_down};
  assign rise     = btn & ~btn_q;
  assign can_rise = rise[2];
  assign sub_rise = rise[3] & ~rise[2];
  assign up_rise  = rise[1];
  assign dn_rise  = rise[0];

  assign key_onehot = (note_key != '0) && ((note_key & (note_key - KEYS'(1))) == '0);
  assign mode_idx   = MW'(key_idx);

  always_comb begin
    key_idx = '0;
    for (int i = 0; i < KEYS; i++)
      if (note_key[i]) key_idx = KW'(i);
  end

  always_comb begin
    state_next   = state_reg;
    mode_en_next = mode_en_reg;
    sel_next     = sel_reg;
    song_next    = song_reg;
    level_next   = level_reg;
    k_next       = k_reg;
    map_we       = 1'b0;
    map_clr      = 1'b0;
    if (can_rise && state_reg != MENU) begin
      state_next   = MENU;
      mode_en_next = '0;
      song_next    = '0;
      k_next       = '0;
    end else begin
      case (state_reg)
        MENU: if (sub_rise && key_onehot) begin
          if (key_idx < NMODES_K) begin
            sel_next = mode_idx;
            if (SONG_MASK[mode_idx]) begin
              state_next = PICK;
              level_next = LVL_INIT_L;
              song_next  = '0;
            end else begin
              state_next   = RUN;
              mode_en_next = NMODES'(1) << mode_idx;
            end
`ifdef MODE_CTRL_MAP_EN
          end else if (key_idx == NMODES_K) begin
            state_next = MAP;
            k_next     = '0;
`endif
          end
        end
        PICK: begin
          if (up_rise && level_reg != LVL_MAX_L) level_next = level_reg + 4'd1;
          else if (dn_rise && level_reg != 4'd0) level_next = level_reg - 4'd1;
          if (sub_rise && key_onehot && key_idx < SONGS_K) begin
            song_next    = SONG_W'(key_idx) + SONG_W'(1);
            state_next   = RUN;
            mode_en_next = NMODES'(1) << sel_reg;
          end
        end
        RUN: if (|(mode_done & mode_en_reg)) begin
          state_next   = MENU;
          mode_en_next = '0;
          song_next    = '0;
        end
`ifdef MODE_CTRL_MAP_EN
        MAP: if (sub_rise) begin
          if (remap_clr) begin
            map_clr    = 1'b1;
            state_next = MENU;
            k_next     = '0;
          end else if (key_onehot) begin
            map_we = 1'b1;
            if (k_reg == K_LAST) begin
              state_next = MENU;
              k_next     = '0;
            end else begin
              k_next = k_reg + KW'(1);
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= MENU;
      mode_en_reg <= '0;
      sel_reg     <= '0;
      song_reg    <= '0;
      level_reg   <= '0;
      k_reg       <= '0;
      btn_q       <= '0;
    end else begin
      state_reg   <= state_next;
      mode_en_reg <= mode_en_next;
      sel_reg     <= sel_next;
      song_reg    <= song_next;
      level_reg   <= level_next;
      k_reg       <= k_next;
      btn_q       <= btn;
    end
  end

`ifdef MODE_CTRL_MAP_EN
  logic [KEYS-1:0] map_reg [KEYS];

  for (genvar gi = 0; gi < KEYS; gi++) begin : g_map
    localparam logic [KEYS-1:0] IDENT = KEYS'(1) << gi;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                 map_reg[gi] <= IDENT;
      else if (map_clr)                           map_reg[gi] <= IDENT;
      else if (map_we && key_idx == KW'(gi))      map_reg[gi] <= KEYS'(1) << k_reg;
    end
  end

  always_comb begin
    key_map = '0;
    for (int i = 0; i < KEYS; i++)
      if (note_key[i]) key_map = key_map | map_reg[i];
  end
`else
  logic remap_unused;
  assign remap_unused = remap_clr;
  assign key_map      = note_key;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg  <= '0;
      tick_reg <= 1'b0;
      time_reg <= '0;
    end else if (div_reg == DW'(CLK_DIV - 1)) begin
      div_reg  <= '0;
      tick_reg <= 1'b1;
      time_reg <= time_reg + TICK_W'(1);
    end else begin
      div_reg  <= div_reg + DW'(1);
      tick_reg <= 1'b0;
    end
  end

  always_comb begin
    buzzer_next = 1'b0;
    led_next    = '0;
    seg_next    = menu_seg;
    case (state_reg)
      PICK: led_next = KEYS'(1) << level_reg;
      RUN: begin
        buzzer_next = eng_buzzer[sel_reg];
        led_next    = eng_led[sel_reg*KEYS +: KEYS];
        seg_next    = eng_seg[sel_reg*3*TUBE_W +: 3*TUBE_W];
      end
      MAP:  led_next = KEYS'(1) << k_reg;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buzzer <= 1'b0;
      led    <= '0;
      seg    <= '0;
    end else begin
      buzzer <= buzzer_next;
      led    <= led_next;
      seg    <= seg_next;
    end
  end

  assign tick     = tick_reg;
  assign sys_time = time_reg;
  assign state    = state_reg;
  assign mode_en  = mode_en_reg;
  assign song     = song_reg;
  assign level    = level_reg;

endmodule

// File: tb/tb_mode_ctrl.sv
// Directed-vector bench for mode_ctrl with CLK_DIV = 10.
module tb_mode_ctrl;
  localparam int KEYS = 7, NMODES = 4, TUBE_W = 8, TICK_W = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  logic submit = 0, cancel = 0, oct_up = 0, oct_down = 0, remap_clr = 0;
  logic [KEYS-1:0] note_key = '0, key_map, led;
  logic tick, buzzer;
  logic [TICK_W-1:0] sys_time;
  logic [1:0] state, song;
  logic [NMODES-1:0] mode_en, mode_done = '0, eng_buzzer = 4'b0001;
  logic [3:0] level;
  logic [NMODES*KEYS-1:0] eng_led = {7'b1110000, 7'b0001111, 7'b0110011, 7'b1010101};
  logic [NMODES*3*TUBE_W-1:0] eng_seg = {24'h778899, 24'h445566, 24'h112233, 24'hA1B2C3};
  logic [3*TUBE_W-1:0] menu_seg = '0, seg;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mode_ctrl #(.KEYS(KEYS), .NMODES(NMODES), .SONG_MASK(4'b1110), .SONGS(3), .LVL_MAX(6),
              .LVL_INIT(4), .CLK_DIV(10), .TICK_W(TICK_W), .TUBE_W(TUBE_W)) dut (
    .clk(clk), .rst_n(rst_n), .submit(submit), .cancel(cancel), .oct_up(oct_up),
    .oct_down(oct_down), .remap_clr(remap_clr), .note_key(note_key), .key_map(key_map),
    .tick(tick), .sys_time(sys_time), .state(state), .mode_en(mode_en), .song(song),
    .level(level), .mode_done(mode_done), .eng_buzzer(eng_buzzer), .eng_led(eng_led),
    .eng_seg(eng_seg), .menu_seg(menu_seg), .buzzer(buzzer), .led(led), .seg(seg));

  task automatic press_submit(input logic [KEYS-1:0] key);
    @(negedge clk); note_key = key; submit = 1'b1;
    @(negedge clk); submit = 1'b0;
  endtask

  task automatic press_up();
    @(negedge clk); oct_up = 1'b1;
    @(negedge clk); oct_up = 1'b0;
  endtask

  task automatic press_down();
    @(negedge clk); oct_down = 1'b1;
    @(negedge clk); oct_down = 1'b0;
  endtask

  task automatic pulse_done(input logic [NMODES-1:0] d);
    @(negedge clk); mode_done = d;
    @(negedge clk); mode_done = '0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (state !== 2'd0 || mode_en !== 4'd0 || song !== 2'd0 || level !== 4'd0) begin
      bad++; $display("FAIL reset_ctrl got state=%0d en=%b song=%0d lvl=%0d exp 0", state, mode_en, song, level); end
    total++; if (tick !== 1'b0 || sys_time !== 16'd0 || led !== 7'd0 || buzzer !== 1'b0 || seg !== 24'd0) begin
      bad++; $display("FAIL reset_out got tick=%b t=%0d led=%b bz=%b seg=%h exp 0", tick, sys_time, led, buzzer, seg); end
    total++; if (key_map !== 7'd0) begin bad++; $display("FAIL reset_keymap got=%b exp=0", key_map); end
    rst_n = 1'b1;
  endtask

  task automatic test_tick();
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      total++; if (tick !== ((n % 10) == 0)) begin
        bad++; $display("FAIL tick_cycle%0d got=%b exp=%b", n, tick, (n % 10) == 0); end
    end
    total++; if (sys_time !== 16'd3) begin bad++; $display("FAIL sys_time got=%0d exp=3", sys_time); end
    total++; if (led !== 7'd0 || buzzer !== 1'b0 || seg !== 24'd0 || mode_en !== 4'd0) begin
      bad++; $display("FAIL idle_out got led=%b bz=%b seg=%h en=%b exp 0", led, buzzer, seg, mode_en); end
  endtask

  task automatic test_run_engine0();
    menu_seg = 24'h5A5A5A;
    press_submit(7'b0000001);
    total++; if (state !== 2'd2 || mode_en !== 4'b0001) begin
      bad++; $display("FAIL run0_enter got state=%0d en=%b exp 2/0001", state, mode_en); end
    @(negedge clk);
    total++; if (seg !== 24'hA1B2C3 || led !== 7'b1010101 || buzzer !== 1'b1) begin
      bad++; $display("FAIL run0_mux got seg=%h led=%b bz=%b exp a1b2c3/1010101/1", seg, led, buzzer); end
    pulse_done(4'b0010);
    total++; if (state !== 2'd2 || mode_en !== 4'b0001) begin
      bad++; $display("FAIL run0_other_done got state=%0d en=%b exp 2/0001", state, mode_en); end
    pulse_done(4'b0001);
    total++; if (state !== 2'd0 || mode_en !== 4'b0000) begin
      bad++; $display("FAIL run0_done got state=%0d en=%b exp 0/0000", state, mode_en); end
    @(negedge clk);
    total++; if (seg !== 24'h5A5A5A || led !== 7'd0 || buzzer !== 1'b0) begin
      bad++; $display("FAIL menu_mux got seg=%h led=%b bz=%b exp 5a5a5a/0/0", seg, led, buzzer); end
  endtask

  task automatic test_menu_ignore();
    press_submit(7'b0000011);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL menu_multi got state=%0d exp=0", state); end
    press_submit(7'b0100000);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL menu_bit5 got state=%0d exp=0", state); end
  endtask

  task automatic test_pick();
    press_submit(7'b0000010);
    total++; if (state !== 2'd1 || level !== 4'd4 || song !== 2'd0 || mode_en !== 4'd0) begin
      bad++; $display("FAIL pick_enter got st=%0d lvl=%0d song=%0d en=%b exp 1/4/0/0", state, level, song, mode_en); end
    @(negedge clk);
    total++; if (led !== 7'b0010000) begin bad++; $display("FAIL pick_led got=%b exp=0010000", led); end
    repeat (3) press_up();
    total++; if (level !== 4'd6) begin bad++; $display("FAIL pick_up_sat got=%0d exp=6", level); end
    @(negedge clk); oct_down = 1'b1;
    repeat (3) @(negedge clk);
    oct_down = 1'b0;
    total++; if (level !== 4'd5) begin bad++; $display("FAIL pick_held_down got=%0d exp=5", level); end
    press_up();
    press_submit(7'b0000100);
    total++; if (state !== 2'd2 || song !== 2'd3 || mode_en !== 4'b0010 || level !== 4'd6) begin
      bad++; $display("FAIL pick_song got st=%0d song=%0d en=%b lvl=%0d exp 2/3/0010/6", state, song, mode_en, level); end
    @(negedge clk);
    total++; if (led !== 7'b0110011 || seg !== 24'h112233 || buzzer !== 1'b0) begin
      bad++; $display("FAIL run1_mux got led=%b seg=%h bz=%b exp 0110011/112233/0", led, seg, buzzer); end
    pulse_done(4'b0010);
    total++; if (state !== 2'd0 || song !== 2'd0 || mode_en !== 4'd0) begin
      bad++; $display("FAIL run1_done got st=%0d song=%0d en=%b exp 0/0/0", state, song, mode_en); end
  endtask

  task automatic test_pick_cancel();
    press_submit(7'b0001000);
    total++; if (state !== 2'd1 || level !== 4'd4) begin
      bad++; $display("FAIL pick3_enter got st=%0d lvl=%0d exp 1/4", state, level); end
    press_submit(7'b0001000);
    total++; if (state !== 2'd1 || song !== 2'd0) begin
      bad++; $display("FAIL pick_bad_song got st=%0d song=%0d exp 1/0", state, song); end
    repeat (5) press_down();
    total++; if (level !== 4'd0) begin bad++; $display("FAIL pick_down_sat got=%0d exp=0", level); end
    @(negedge clk); note_key = 7'b0000001; submit = 1'b1; cancel = 1'b1;
    @(negedge clk); submit = 1'b0; cancel = 1'b0;
    total++; if (state !== 2'd0 || song !== 2'd0 || mode_en !== 4'd0) begin
      bad++; $display("FAIL pick_cancel got st=%0d song=%0d en=%b exp 0/0/0", state, song, mode_en); end
  endtask

  task automatic test_reset_mid();
    press_submit(7'b0000010);
    @(negedge clk); note_key = 7'b1000000; rst_n = 1'b0; #1;
    total++; if (state !== 2'd0 || level !== 4'd0 || led !== 7'd0 || sys_time !== 16'd0) begin
      bad++; $display("FAIL reset_mid got st=%0d lvl=%0d led=%b t=%0d exp 0", state, level, led, sys_time); end
    total++; if (key_map !== 7'b1000000) begin bad++; $display("FAIL reset_mid_map got=%b exp=1000000", key_map); end
    @(negedge clk); rst_n = 1'b1;
  endtask

`ifdef MODE_CTRL_MAP_EN
  task automatic test_map();
    press_submit(7'b0010000);
    total++; if (state !== 2'd3) begin bad++; $display("FAIL map_enter got state=%0d exp=3", state); end
    @(negedge clk);
    total++; if (led !== 7'b0000001) begin bad++; $display("FAIL map_led0 got=%b exp=0000001", led); end
    for (int i = 0; i < 3; i++) press_submit(7'(1) << (6 - i));
    press_submit(7'b0000011);
    total++; if (state !== 2'd3 || led !== 7'b0001000) begin
      bad++; $display("FAIL map_ignore got st=%0d led=%b exp 3/0001000", state, led); end
    for (int i = 3; i < 6; i++) press_submit(7'(1) << (6 - i));
    total++; if (state !== 2'd3) begin bad++; $display("FAIL map_k6 got state=%0d exp=3", state); end
    press_submit(7'b0000001);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL map_done got state=%0d exp=0", state); end
    @(negedge clk); note_key = 7'b1000000; #1;
    total++; if (key_map !== 7'b0000001) begin bad++; $display("FAIL map_k6_out got=%b exp=0000001", key_map); end
    note_key = 7'b0000001; #1;
    total++; if (key_map !== 7'b1000000) begin bad++; $display("FAIL map_k0_out got=%b exp=1000000", key_map); end
    note_key = 7'b1000010; #1;
    total++; if (key_map !== 7'b0100001) begin bad++; $display("FAIL map_or got=%b exp=0100001", key_map); end
    note_key = 7'b0000000; #1;
    total++; if (key_map !== 7'b0000000) begin bad++; $display("FAIL map_none got=%b exp=0", key_map); end
  endtask

  task automatic test_remap_clr();
    press_submit(7'b0010000);
    for (int i = 0; i < 3; i++) press_submit(7'(1) << (6 - i));
    @(negedge clk); note_key = 7'b0100000; #1;
    total++; if (key_map !== 7'b0000010) begin bad++; $display("FAIL remap_pre got=%b exp=0000010", key_map); end
    remap_clr = 1'b1;
    press_submit(7'b0000000);
    remap_clr = 1'b0;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL remap_state got=%0d exp=0", state); end
    note_key = 7'b0100000; #1;
    total++; if (key_map !== 7'b0100000) begin bad++; $display("FAIL remap_ident got=%b exp=0100000", key_map); end
  endtask
`else
  task automatic test_no_map();
    press_submit(7'b0010000);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL nomap_state got=%0d exp=0", state); end
    @(negedge clk); note_key = 7'b0101010; #1;
    total++; if (key_map !== 7'b0101010) begin bad++; $display("FAIL nomap_keys got=%b exp=0101010", key_map); end
    note_key = 7'b1000001; #1;
    total++; if (key_map !== 7'b1000001) begin bad++; $display("FAIL nomap_keys2 got=%b exp=1000001", key_map); end
  endtask
`endif

  initial begin
    test_reset();
    test_tick();
    test_run_engine0();
    test_menu_ignore();
    test_pick();
    test_pick_cancel();
`ifdef MODE_CTRL_MAP_EN
    test_map();
    test_reset_mid();
    test_remap_clr();
`else
    test_reset_mid();
    test_no_map();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
